// File: rtl/float_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack, multiply, normalise/round/pack)
// with valid/ready handshake, overflow saturation, underflow flush and a tag passthrough.
module float_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int ROUND = 0,
    parameter int TAG_W = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_y,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_ovf,
    output logic                   out_uf
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [EW-1:0]        BIAS = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EONE = EW'(1);
    localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);
    localparam logic [MAN_W:0]       HALF = {1'b1, {MAN_W{1'b0}}};

    logic advance;

    logic                    s1_valid, s1_zero, s1_sign;
    logic signed [EW-1:0]    s1_exp;
    logic [MAN_W:0]          s1_man_a, s1_man_b;
    logic [TAG_W-1:0]        s1_tag;

    logic                    s2_valid, s2_zero, s2_sign;
    logic signed [EW-1:0]    s2_exp;
    logic [PW-1:0]           s2_prod;
    logic [TAG_W-1:0]        s2_tag;

    logic                    in_zero;
    logic signed [EW-1:0]    exp_sum;

    logic signed [EW-1:0]    e_norm, e_final;
    logic [MAN_W-1:0]        mant;
    logic [MAN_W:0]          rem, mant_rnd;
    logic                    round_up;
    logic [W-1:0]            y_next;
    logic                    ovf_next, uf_next;

    // A single global stall: every stage moves only when the output slot can drain.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        in_zero = (a[W-2 -: EXP_W] == '0) || (b[W-2 -: EXP_W] == '0);
        exp_sum = {2'b00, a[W-2 -: EXP_W]} + {2'b00, b[W-2 -: EXP_W]} - BIAS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_man_a <= '0;
            s1_man_b <= '0;
            s1_tag   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_zero  <= in_zero;
                s1_sign  <= a[W-1] ^ b[W-1];
                s1_exp   <= exp_sum;
                s1_man_a <= {1'b1, a[MAN_W-1:0]};
                s1_man_b <= {1'b1, b[MAN_W-1:0]};
                s1_tag   <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_prod  <= '0;
            s2_tag   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_zero  <= s1_zero;
                s2_sign  <= s1_sign;
                s2_exp   <= s1_exp;
                s2_prod  <= s1_man_a * s1_man_b;
                s2_tag   <= s1_tag;
            end
        end
    end

    // The product of two [1,2) significands lies in [1,4); a set top bit means one extra shift.
    always_comb begin
        if (s2_prod[PW-1]) begin
            e_norm = s2_exp + EONE;
            mant   = s2_prod[PW-2 -: MAN_W];
            rem    = s2_prod[MAN_W:0];
        end else begin
            e_norm = s2_exp;
            mant   = s2_prod[PW-3 -: MAN_W];
            rem    = {s2_prod[MAN_W-1:0], 1'b0};
        end
        round_up = (ROUND != 0) && ((rem > HALF) || ((rem == HALF) && mant[0]));
        mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        e_final  = mant_rnd[MAN_W] ? e_norm + EONE : e_norm;

        y_next   = '0;
        ovf_next = 1'b0;
        uf_next  = 1'b0;
        if (s2_zero) begin
            y_next = '0;
        end else if (e_final > EMAX) begin
            y_next   = {s2_sign, {(W-1){1'b1}}};
            ovf_next = 1'b1;
        end else if (e_final < EONE) begin
            uf_next = 1'b1;
        end else begin
            y_next = {s2_sign, e_final[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
            out_uf    <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_y   <= y_next;
                out_tag <= s2_tag;
                out_ovf <= ovf_next;
                out_uf  <= uf_next;
            end
        end
    end
endmodule

// File: tb/tb_float_mul_pipe.sv
// Testbench for float_mul_pipe: a truncating and a rounding instance share the same stimulus
// and are scored against an integer-arithmetic reference model through per-instance queues.
module tb_float_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [15:0] a, b;
    logic [5:0]  in_tag;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [15:0] out_y0, out_y1;
    logic [5:0]  out_tag0, out_tag1;
    logic        ovf0, ovf1, uf0, uf1;

    always #5 clk = ~clk;

    float_mul_pipe #(.EXP_W(8), .MAN_W(7), .ROUND(0), .TAG_W(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready),
        .out_y(out_y0), .out_tag(out_tag0), .out_ovf(ovf0), .out_uf(uf0)
    );

    float_mul_pipe #(.EXP_W(8), .MAN_W(7), .ROUND(1), .TAG_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready),
        .out_y(out_y1), .out_tag(out_tag1), .out_ovf(ovf1), .out_uf(uf1)
    );

    typedef struct packed {
        logic [15:0] y;
        logic [5:0]  tag;
        logic        ovf;
        logic        uf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y0;
        logic [15:0] y1;
        logic        ovf;
        logic        uf;
    } vec_t;

    res_t q0[$];
    res_t q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference: exact integer product of significands, then scale, round and range-check.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] z,
                                   input logic [5:0] tag, input bit rnd);
        res_t r;
        int   ex, ez, e, p, sh, sig, rem, half;
        bit   s;
        r.tag = tag; r.ovf = 1'b0; r.uf = 1'b0; r.y = '0;
        ex = int'(x[14:7]);
        ez = int'(z[14:7]);
        s  = x[15] ^ z[15];
        if (ex == 0 || ez == 0) return r;
        p = (128 + int'(x[6:0])) * (128 + int'(z[6:0]));
        e = ex + ez - 127;
        if (p >= 32768) begin sh = 8; e++; end else sh = 7;
        sig  = p >> sh;
        rem  = p - (sig << sh);
        half = 1 << (sh - 1);
        if (rnd && (rem > half || (rem == half && sig % 2 == 1))) sig++;
        if (sig == 256) begin sig = 128; e++; end
        if (e > 255) begin
            r.y = {s, 15'h7FFF}; r.ovf = 1'b1;
        end else if (e < 1) begin
            r.uf = 1'b1;
        end else begin
            r.y = {s, 8'(e), 7'(sig)};
        end
        return r;
    endfunction

    function automatic res_t mk(input logic [15:0] y, input logic [5:0] tag,
                                input logic ovf, input logic uf);
        res_t r;
        r.y = y; r.tag = tag; r.ovf = ovf; r.uf = uf;
        return r;
    endfunction

    task automatic popCheck(input int which);
        res_t        e;
        logic [15:0] y;
        logic [5:0]  t;
        logic        o, u, v;
        if (which == 0) begin v = out_valid0; y = out_y0; t = out_tag0; o = ovf0; u = uf0; end
        else            begin v = out_valid1; y = out_y1; t = out_tag1; o = ovf1; u = uf1; end
        if (!v) return;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            checkOutput($sformatf("dut%0d spurious out_valid", which), v, 1'b0);
            return;
        end
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput($sformatf("dut%0d y", which),   y, e.y);
        checkOutput($sformatf("dut%0d tag", which), t, e.tag);
        checkOutput($sformatf("dut%0d ovf", which), o, e.ovf);
        checkOutput($sformatf("dut%0d uf", which),  u, e.uf);
    endtask

    // One clock: drive at the falling edge, score the handshake, then step to the next falling edge.
    task automatic applyStimulus(input bit v, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [5:0] tg, input bit ordy,
                                 input res_t e0, input res_t e1, output bit accepted);
        in_valid = v; a = av; b = bv; in_tag = tg; out_ready = ordy;
        #1;
        accepted = v && in_ready0;
        if (ordy) begin
            popCheck(0);
            popCheck(1);
        end
        if (accepted) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issueModel(input logic [15:0] av, input logic [15:0] bv, input logic [5:0] tg,
                              input bit ordy, output bit accepted);
        applyStimulus(1'b1, av, bv, tg, ordy, model(av, bv, tg, 1'b0), model(av, bv, tg, 1'b1), accepted);
    endtask

    task automatic bubble(input bit ordy);
        bit acc;
        applyStimulus(1'b0, 16'h0, 16'h0, 6'h0, ordy, mk(0, 0, 0, 0), mk(0, 0, 0, 0), acc);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) bubble(1'b1);
        checkOutput({name, " dut0 results missing"}, q0.size(), 0);
        checkOutput({name, " dut1 results missing"}, q1.size(), 0);
    endtask

    initial begin
        vec_t        vecs[11];
        bit          acc;
        int          idx;
        logic [15:0] bpa[5];
        logic [15:0] bpb[5];
        logic [15:0] x, z;

        vecs[0]  = '{16'h4000, 16'h4040, 16'h40C0, 16'h40C0, 1'b0, 1'b0};
        vecs[1]  = '{16'hC000, 16'h4040, 16'hC0C0, 16'hC0C0, 1'b0, 1'b0};
        vecs[2]  = '{16'h3FC0, 16'h3FC0, 16'h4010, 16'h4010, 1'b0, 1'b0};
        vecs[3]  = '{16'h0000, 16'h4040, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{16'h0040, 16'h4040, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{16'h0080, 16'h0080, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[6]  = '{16'h7F00, 16'h7F00, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
        vecs[7]  = '{16'hFF00, 16'h7F00, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h7F00, 16'h4000, 16'h7F80, 16'h7F80, 1'b0, 1'b0};
        vecs[9]  = '{16'h3FC0, 16'h3F81, 16'h3FC1, 16'h3FC2, 1'b0, 1'b0};
        vecs[10] = '{16'h3FFF, 16'h3FFF, 16'h407E, 16'h407E, 1'b0, 1'b0};

        // Reset values while rst_n is held low, then release away from a rising edge.
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; in_tag = '0;
        @(negedge clk); @(negedge clk);
        checkOutput("reset out_valid", out_valid0, 1'b0);
        checkOutput("reset out_y",     out_y0, 16'h0);
        checkOutput("reset out_tag",   out_tag0, 6'h0);
        checkOutput("reset out_ovf",   ovf0, 1'b0);
        checkOutput("reset out_uf",    uf0, 1'b0);
        checkOutput("reset in_ready",  in_ready0, 1'b1);
        checkOutput("reset dut1 out_valid", out_valid1, 1'b0);
        rst_n = 1'b1;

        // Latency: first directed op then bubbles; result appears after the third edge.
        applyStimulus(1'b1, vecs[0].a, vecs[0].b, 6'd5, 1'b1,
                      mk(vecs[0].y0, 6'd5, vecs[0].ovf, vecs[0].uf),
                      mk(vecs[0].y1, 6'd5, vecs[0].ovf, vecs[0].uf), acc);
        checkOutput("latency accepted", acc, 1'b1);
        checkOutput("latency edge1 out_valid", out_valid0, 1'b0);
        bubble(1'b1);
        checkOutput("latency edge2 out_valid", out_valid0, 1'b0);
        bubble(1'b1);
        checkOutput("latency edge3 out_valid", out_valid0, 1'b1);
        drain("latency");

        // Directed vectors streamed back to back.
        for (int i = 1; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, 6'(5 + i), 1'b1,
                          mk(vecs[i].y0, 6'(5 + i), vecs[i].ovf, vecs[i].uf),
                          mk(vecs[i].y1, 6'(5 + i), vecs[i].ovf, vecs[i].uf), acc);
            checkOutput("directed accepted", acc, 1'b1);
        end
        drain("directed");

        // Backpressure: only three ops fit before in_ready drops; output must hold steady.
        for (int i = 0; i < 5; i++) begin bpa[i] = 16'($urandom); bpb[i] = 16'($urandom); end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            issueModel(bpa[idx], bpb[idx], 6'(40 + idx), 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("bp ops accepted", idx, 3);
        checkOutput("bp in_ready low", in_ready0, 1'b0);
        checkOutput("bp out_valid",    out_valid0, 1'b1);
        checkOutput("bp held y",       out_y0, q0[0].y);
        checkOutput("bp held tag",     out_tag0, q0[0].tag);
        for (int c = 0; c < 30 && (idx < 5 || q0.size() != 0); c++) begin
            if (idx < 5) begin
                issueModel(bpa[idx], bpb[idx], 6'(40 + idx), 1'b1, acc);
                if (acc) idx++;
            end else begin
                bubble(1'b1);
            end
        end
        checkOutput("bp all issued", idx, 5);
        drain("backpressure");

        // Reset mid-flight with a stalled result at the output.
        for (int i = 0; i < 3; i++) issueModel(16'h4000, 16'h4040, 6'(50 + i), 1'b0, acc);
        checkOutput("mid reset pre out_valid", out_valid0, 1'b1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid reset out_valid", out_valid0, 1'b0);
        checkOutput("mid reset in_ready",  in_ready0, 1'b1);
        checkOutput("mid reset out_y",     out_y0, 16'h0);
        #1 rst_n = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 4; i++) begin
            bubble(1'b1);
            checkOutput("post reset dut0 stale", out_valid0, 1'b0);
            checkOutput("post reset dut1 stale", out_valid1, 1'b0);
        end
        issueModel(16'h3FC0, 16'h3F81, 6'd33, 1'b1, acc);
        checkOutput("post reset edge1", out_valid0, 1'b0);
        bubble(1'b1);
        checkOutput("post reset edge2", out_valid0, 1'b0);
        bubble(1'b1);
        checkOutput("post reset edge3", out_valid0, 1'b1);
        drain("post reset");

        // Random traffic with random bubbles and backpressure.
        for (int c = 0; c < 400; c++) begin
            x = 16'($urandom);
            z = 16'($urandom);
            if ($urandom_range(0, 3) != 0)
                issueModel(x, z, 6'($urandom), ($urandom_range(0, 3) != 0), acc);
            else
                bubble($urandom_range(0, 3) != 0);
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
